// File: rtl/doom_pkg.sv
// rtl/doom_pkg.sv - shared doom_fpga command-interface definitions
//
// Purpose: issuer FSM state encoding, default slave register addresses and
// the CMD_* command codes understood by the doom_fpga slave port.
// Ports: none (package).
package doom_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_BASE   = 3'd1;
  localparam state_t ST_WR_CMD    = 3'd2;
  localparam state_t ST_RD_STATUS = 3'd3;
  localparam state_t ST_RESP      = 3'd4;

  localparam logic [7:0] ADDR_CMD_DEFAULT  = 8'd0;
  localparam logic [7:0] ADDR_BASE_DEFAULT = 8'd1;

  localparam logic [31:0] CMD_V_Init         = 32'h0000_0001;
  localparam logic [31:0] CMD_V_StartFrame   = 32'h0000_0002;
  localparam logic [31:0] CMD_V_FinishUpdate = 32'h0000_0003;
  localparam logic [31:0] CMD_I_GetEvent     = 32'h0000_0004;

  // True in the states that own an Avalon transfer.
  function automatic logic is_xfer(input state_t s);
    return (s == ST_WR_BASE) || (s == ST_WR_CMD) || (s == ST_RD_STATUS);
  endfunction

endpackage

// File: rtl/doom_cmd_issuer_if.sv
// rtl/doom_cmd_issuer_if.sv - command, response and Avalon-MM signal bundle
//
// Purpose: groups the issuer's request/response handshakes and its Avalon
// master bus. modport master = issuer side, modport slave = environment side
// (requester, response consumer and the doom_fpga slave).
// Ports: cmd_valid/cmd_ready/cmd_code/cmd_base/cmd_base_en request,
//        rsp_valid/rsp_ready/rsp_status/rsp_cycles/rsp_timeout response,
//        m_address/m_read/m_write/m_writedata/m_readdata/m_waitrequest bus.
interface doom_cmd_issuer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_code;
  logic [31:0] cmd_base;
  logic        cmd_base_en;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_status;
  logic [31:0] rsp_cycles;
  logic        rsp_timeout;

  logic [7:0]  m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  cmd_valid, cmd_code, cmd_base, cmd_base_en, rsp_ready,
           m_readdata, m_waitrequest,
    output cmd_ready, rsp_valid, rsp_status, rsp_cycles, rsp_timeout,
           m_address, m_read, m_write, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_base, cmd_base_en, rsp_ready,
           m_readdata, m_waitrequest,
    input  cmd_ready, rsp_valid, rsp_status, rsp_cycles, rsp_timeout,
           m_address, m_read, m_write, m_writedata
  );

endinterface

// File: rtl/doom_sat_counter.sv
// rtl/doom_sat_counter.sv - saturating up-counter with clear and enable
//
// Purpose: counts enabled cycles and sticks at all-ones.
// Ports: clk, rst_n (async active-low), clr, en, count[WIDTH-1:0].
module doom_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      // Clear together with enable restarts the count including this cycle.
      count <= en ? WIDTH'(1) : '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/doom_cmd_issuer.sv
// rtl/doom_cmd_issuer.sv - Avalon-MM master that issues one doom_fpga command
//
// Purpose: accepts a request, optionally writes the shared-memory base,
// writes the command code, reads back status and returns status, elapsed
// cycles and a timeout flag.
// Ports: clk, reset_n (async active-low), bus (doom_cmd_issuer_if.master).
module doom_cmd_issuer
  import doom_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ADDR_CMD       = ADDR_CMD_DEFAULT,
  parameter logic [7:0] ADDR_BASE      = ADDR_BASE_DEFAULT
) (
  input logic               clk,
  input logic               reset_n,
  doom_cmd_issuer_if.master bus
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [31:0]       code_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              xfer;
  logic              accept;
  logic              done;
  logic              timeout_hit;

  assign xfer        = is_xfer(state);
  assign accept      = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign done        = xfer && !bus.m_waitrequest;
  // This cycle would be stall number TIMEOUT_CYCLES: abort instead of waiting.
  assign timeout_hit = xfer && bus.m_waitrequest && (wait_cnt == WAIT_LAST);

  // The accept cycle counts as 1, then every transfer cycle adds one.
  doom_sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (accept),
    .en    (accept | xfer),
    .count (bus.rsp_cycles)
  );

  // Stall counter restarts for every transfer.
  doom_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (accept | done | timeout_hit),
    .en    (xfer & bus.m_waitrequest & ~timeout_hit),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      code_q          <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.m_read      <= 1'b0;
      bus.m_write     <= 1'b0;
      bus.m_address   <= '0;
      bus.m_writedata <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_status  <= '0;
      bus.rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      // Debug escape: drops the request while the slave still stalls.
      bus.m_read      <= 1'b0;
      bus.m_write     <= 1'b0;
      bus.rsp_timeout <= 1'b1;
      bus.rsp_valid   <= 1'b1;
      state           <= ST_RESP;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept) begin
            bus.cmd_ready   <= 1'b0;
            code_q          <= bus.cmd_code;
            bus.rsp_status  <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.m_write     <= 1'b1;
            if (bus.cmd_base_en) begin
              bus.m_address   <= ADDR_BASE;
              bus.m_writedata <= bus.cmd_base;
              state           <= ST_WR_BASE;
            end else begin
              bus.m_address   <= ADDR_CMD;
              bus.m_writedata <= bus.cmd_code;
              state           <= ST_WR_CMD;
            end
          end
        end
        ST_WR_BASE: begin
          if (!bus.m_waitrequest) begin
            bus.m_address   <= ADDR_CMD;
            bus.m_writedata <= code_q;
            state           <= ST_WR_CMD;
          end
        end
        ST_WR_CMD: begin
          if (!bus.m_waitrequest) begin
            bus.m_write <= 1'b0;
            bus.m_read  <= 1'b1;
            state       <= ST_RD_STATUS;
          end
        end
        ST_RD_STATUS: begin
          if (!bus.m_waitrequest) begin
            bus.rsp_status <= bus.m_readdata;
            bus.m_read     <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/doom_cmd_issuer.md
Name: doom_cmd_issuer

Overview:
- FPGA-side Avalon-MM master that drives the doom_fpga HPS-facing slave port. It is the initiator end of that command interface.
- Accepts one command request via valid/ready, then performs three transfers on the slave: writes the shared-memory base (address 1), writes the command code (address 0), and reads back status (address 0).
- Returns status, elapsed cycles and a timeout flag via a valid/ready response.
- Used for standalone bring-up and regression of doom_fpga without the HPS, and as a profiling hook.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, max consecutive waitrequest-high cycles tolerated on any single transfer before abort.
- ADDR_CMD, 8'd0, slave word address of the command/status register.
- ADDR_BASE, 8'd1, slave word address of the shared-memory base register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  block can accept a request
- cmd_code  in  32  command code (CMD_* constants)
- cmd_base  in  32  shared-memory base address
- cmd_base_en  in  1  1 = write base before command; 0 = skip the base write
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_status  out  32  readdata captured from the status read
- rsp_cycles  out  32  cycles from accept to completion, saturating at 32'hFFFF_FFFF
- rsp_timeout  out  1  transfer aborted on timeout
- m_address  out  8  Avalon address
- m_read  out  1  Avalon read
- m_write  out  1  Avalon write
- m_writedata  out  32  Avalon write data
- m_readdata  in  32  Avalon read data
- m_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, reset_n low):
  - Outputs: cmd_ready=0, m_read=0, m_write=0, m_address=0, m_writedata=0, rsp_valid=0, rsp_status=0, rsp_cycles=0, rsp_timeout=0.
  - State=IDLE; registers cmd_code, cmd_base, wait counter and cycle counter cleared.
  - cmd_ready rises on the first clk edge after reset release.
- Reset mid-transfer drops the request at once. A request that had been accepted produces no response.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch code/base/base_en and clear counters. Go to WR_BASE if base_en=1, else WR_CMD.
  - WR_BASE: m_write=1, m_address=ADDR_BASE, m_writedata=base. Advance to WR_CMD on a cycle with m_waitrequest=0.
  - WR_CMD: m_write=1, m_address=ADDR_CMD, m_writedata=code. Advance to RD_STATUS on a cycle with m_waitrequest=0.
  - RD_STATUS: m_read=1, m_address=ADDR_CMD. On m_waitrequest=0, capture m_readdata into rsp_status, then go to RESP.
  - RESP: rsp_valid=1, all outputs stable. On rsp_ready, go to IDLE with cmd_ready=1 the next cycle.
- Avalon rules:
  - m_address, m_writedata, m_read and m_write are registered and held stable while m_waitrequest=1.
  - m_read and m_write are never both high.
  - Read latency is 0: readdata is valid in the cycle waitrequest is low.
- Latency with waitrequest always low and base_en=1:
  - accept at edge T
  - WR_BASE during T+1, WR_CMD during T+2, RD_STATUS during T+3
  - rsp_valid high from T+4
  - rsp_cycles=4
- With base_en=0, every step is one cycle earlier and rsp_cycles=3.
- rsp_cycles counts every cycle outside IDLE/RESP, saturating. Count starts at 1 in the first transfer cycle.
- Timeout:
  - A wait counter resets at the start of each transfer and increments on each cycle with m_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, deassert m_read/m_write, set rsp_timeout=1, leave rsp_status=0 and go to RESP.
  - This abort violates Avalon hold rules deliberately; it is a debug-only escape.
- cmd_valid outside IDLE is ignored because cmd_ready=0.
- A held rsp_valid with rsp_ready low blocks indefinitely; no overwrite.

Decomposition:
- Shared package doom_pkg holds:
  - state enum (IDLE, WR_BASE, WR_CMD, RD_STATUS, RESP)
  - ADDR_CMD / ADDR_BASE defaults
  - CMD_* codes (CMD_V_Init, etc.), shared with doom_fpga
- One natural sub-module: doom_sat_counter, a 32-bit saturating counter with clear and enable. It is instantiated for rsp_cycles; the wait counter reuses it at parameterized width.

Test Plan:
1. Zero-wait, base_en=1, base=32'h3000_0000, code=CMD_V_Init, slave readdata=32'h1:
   - Expect write @1 of 32'h3000_0000, then write @0 of CMD_V_Init, then read @0.
   - rsp_valid at T+4 with status=1, cycles=4, timeout=0.
2. base_en=0:
   - No write to address 1.
   - rsp_cycles=3.
3. Slave holds waitrequest 5 cycles on WR_CMD:
   - address and writedata stable for all 6 cycles.
   - rsp_cycles=9.
4. TIMEOUT_CYCLES=16, waitrequest stuck high in RD_STATUS:
   - m_read drops after 16 stall cycles.
   - rsp_timeout=1, rsp_status=0.
5. Hold rsp_ready=0 for 10 cycles with cmd_valid=1:
   - rsp stays valid and unchanged, cmd_ready=0.
   - After rsp_ready, the next command is accepted 1 cycle later.
6. Assert reset_n=0 during WR_CMD stall:
   - m_write=0 immediately (asynchronous).
   - No rsp_valid.
   - cmd_ready=1 one edge after release.
